// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DROP} fetch_state_t;

   localparam int unsigned INSTR_BYTES = 4;

   // Clears the two low address bits; callers narrow the result to their width.
   function automatic logic [63:0] align4(input logic [63:0] addr);
      return {addr[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program-counter register: reset, aligned redirect load, or advance by one instruction.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int unsigned           WIDTH    = 32,
   parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   input  logic             advance_i,
   output logic [WIDTH-1:0] pc_o,
   output logic             misalign_err_o
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             misalign_q, misalign_d;

   // Redirect wins over advance; the increment wraps modulo 2^WIDTH.
   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (redirect_i) begin
         pc_d       = WIDTH'(align4(64'(redirect_pc_i)));
         misalign_d = |redirect_pc_i[1:0];
      end else if (advance_i) begin
         pc_d = pc_q + WIDTH'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc_o           = pc_q;
   assign misalign_err_o = misalign_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: one outstanding imem request, stale-response drop on redirect, valid/ready to decode.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_en,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             instr_valid,
   output logic [WIDTH-1:0] instr,
   output logic [WIDTH-1:0] instr_pc,
   input  logic             instr_ready,
   output logic             misalign_err
);

   fetch_state_t     state_q, state_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] ipc_q, ipc_d;
   logic [WIDTH-1:0] pc;
   logic             redir;
   logic             advance;

   assign redir = redirect_en && (state_q != IDLE);

   fetch_pc_reg #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .redirect_i     (redir),
      .redirect_pc_i  (redirect_pc),
      .advance_i      (advance),
      .pc_o           (pc),
      .misalign_err_o (misalign_err)
   );

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      advance = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            // A grant coinciding with a redirect is for the old pc: its data must be dropped.
            if (redir)         state_d = imem_gnt ? DROP : REQ;
            else if (imem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (redir) begin
               state_d = imem_rvalid ? REQ : DROP;
            end else if (imem_rvalid) begin
               instr_d = imem_rdata;
               ipc_d   = pc;
               valid_d = 1'b1;
               state_d = OUT;
            end
         end
         OUT: begin
            if (redir) begin
               valid_d = 1'b0;
               state_d = REQ;
            end else if (instr_ready) begin
               advance = 1'b1;
               valid_d = 1'b0;
               state_d = REQ;
            end
         end
         DROP: if (imem_rvalid) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         instr_q <= '0;
         ipc_q   <= RESET_PC;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small latency-configurable memory responder.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        misalign_err;

   int          errors = 0;
   int          checks = 0;

   int          lat = 1;
   logic        force_en = 1'b0;
   logic [31:0] force_addr = '0;
   logic [31:0] force_val = '0;

   instr_fetch_unit #(
      .WIDTH    (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .redirect_en  (redirect_en),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_ready  (instr_ready),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory responder: records req&gnt at posedge, drives rvalid from negedge, lat cycles after grant.
   initial begin : mem_model
      logic        pending;
      int          cnt;
      logic [31:0] pdata;
      pending     = 1'b0;
      cnt         = 0;
      pdata       = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(posedge clk);
         if (rst_n && imem_rvalid && imem_req) begin
            errors++;
            $display("FAIL proto_rvalid_in_req: rvalid=%b req=%b required no overlap", imem_rvalid, imem_req);
         end
         if (rst_n && imem_req && imem_gnt) begin
            pending = 1'b1;
            cnt     = lat;
            pdata   = (force_en && imem_addr == force_addr) ? force_val : mdata(imem_addr);
         end
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else if (pending) begin
            if (cnt <= 1) begin
               imem_rvalid = 1'b1;
               imem_rdata  = pdata;
               pending     = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", instr_valid); end
      checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp 0", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_ipc: got %h exp 0", instr_pc); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b exp 0", misalign_err); end
      rst_n = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b exp 1", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h exp 0", imem_addr); end
   endtask

   task automatic test_sequential();
      logic [31:0] a;
      for (int k = 0; k < 3; k++) begin
         a = 32'(4 * k);
         checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL seq_req%0d: got req=%b addr=%h exp 1 %h", k, imem_req, imem_addr, a); end
         tick();
         checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_wait%0d: got req=%b valid=%b exp 0 0", k, imem_req, instr_valid); end
         tick();
         checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b exp 1", k, instr_valid); end
         checks++; if (instr !== mdata(a)) begin errors++; $display("FAIL seq_instr%0d: got %h exp %h", k, instr, mdata(a)); end
         checks++; if (instr_pc !== a) begin errors++; $display("FAIL seq_ipc%0d: got %h exp %h", k, instr_pc, a); end
         tick();
      end
   endtask

   task automatic test_ready_stall();
      instr_ready = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== mdata(32'hC) || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall%0d: got valid=%b pc=%h instr=%h req=%b exp 1 0000000c %h 0", i, instr_valid, instr_pc, instr, imem_req, mdata(32'hC));
         end
         tick();
      end
      instr_ready = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_next: got req=%b addr=%h exp 1 00000010", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_wait();
      lat        = 3;
      force_en   = 1'b1;
      force_addr = 32'h10;
      force_val  = 32'hDEAD_BEEF;
      tick();
      redirect_en = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect_en = 1'b0;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_drop: got req=%b addr=%h exp 0 00000100", imem_req, imem_addr); end
      checks++; if (instr_valid !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rw_flags: got valid=%b mis=%b exp 0 0", instr_valid, misalign_err); end
      tick();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rw_drop2: got req=%b valid=%b exp 0 0", imem_req, instr_valid); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL rw_req: got req=%b addr=%h valid=%b exp 1 00000100 0", imem_req, imem_addr, instr_valid); end
      lat      = 1;
      force_en = 1'b0;
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mdata(32'h100)) begin errors++; $display("FAIL rw_out: got valid=%b pc=%h instr=%h exp 1 00000100 %h", instr_valid, instr_pc, instr, mdata(32'h100)); end
      tick();
   endtask

   task automatic test_redirect_grant();
      imem_gnt    = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 32'h8;
      tick();
      redirect_en = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL rg_req8: got req=%b addr=%h exp 1 00000008", imem_req, imem_addr); end
      imem_gnt    = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_en = 1'b0;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL rg_drop: got req=%b addr=%h exp 0 00000040", imem_req, imem_addr); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin errors++; $display("FAIL rg_req40: got req=%b addr=%h valid=%b exp 1 00000040 0", imem_req, imem_addr, instr_valid); end
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== mdata(32'h40)) begin errors++; $display("FAIL rg_out: got valid=%b pc=%h instr=%h exp 1 00000040 %h", instr_valid, instr_pc, instr, mdata(32'h40)); end
      tick();
   endtask

   task automatic test_misalign();
      imem_gnt    = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_en = 1'b0;
      checks++; if (misalign_err !== 1'b1 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL mis_pulse: got mis=%b addr=%h req=%b exp 1 00000200 1", misalign_err, imem_addr, imem_req); end
      tick();
      checks++; if (misalign_err !== 1'b0 || imem_addr !== 32'h200) begin errors++; $display("FAIL mis_clear: got mis=%b addr=%h exp 0 00000200", misalign_err, imem_addr); end
      imem_gnt = 1'b1;
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin errors++; $display("FAIL mis_out: got valid=%b pc=%h exp 1 00000200", instr_valid, instr_pc); end
      tick();
      checks++; if (imem_addr !== 32'h204) begin errors++; $display("FAIL mis_next: got %h exp 00000204", imem_addr); end
   endtask

   task automatic test_wrap();
      imem_gnt    = 1'b0;
      redirect_en = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_en = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC || misalign_err !== 1'b0) begin errors++; $display("FAIL wrap_load: got addr=%h mis=%b exp fffffffc 0", imem_addr, misalign_err); end
      imem_gnt = 1'b1;
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out: got valid=%b pc=%h exp 1 fffffffc", instr_valid, instr_pc); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got req=%b addr=%h exp 1 00000000", imem_req, imem_addr); end
   endtask

   task automatic test_reset_in_wait();
      repeat (6) tick();
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL riw_pre_addr: got %h exp 00000008", imem_addr); end
      tick();
      checks++; if (instr_pc !== 32'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL riw_pre_wait: got pc=%h req=%b exp 00000004 0", instr_pc, imem_req); end
      rst_n = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL riw_req: got req=%b addr=%h exp 0 00000000", imem_req, imem_addr); end
      checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
         errors++; $display("FAIL riw_outs: got valid=%b instr=%h pc=%h mis=%b exp 0 0 0 0", instr_valid, instr, instr_pc, misalign_err);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL riw_restart: got req=%b addr=%h exp 1 00000000", imem_req, imem_addr); end
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mdata(32'h0)) begin errors++; $display("FAIL riw_out: got valid=%b pc=%h instr=%h exp 1 00000000 %h", instr_valid, instr_pc, instr, mdata(32'h0)); end
   endtask

   initial begin
      rst_n       = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = '0;
      imem_gnt    = 1'b1;
      instr_ready = 1'b1;
      repeat (3) tick();
      test_reset();
      test_sequential();
      test_ready_stall();
      test_redirect_wait();
      test_redirect_grant();
      test_misalign();
      test_wrap();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
